// File: rtl/msg_arbiter_pkg.sv
// Shared framing definitions for the slave-to-UART response path.
// N_SRC default comes from `N_SRC; the checksum byte is enabled by MSG_ARBITER_CHK_EN.
`ifndef N_SRC
`define N_SRC 24
`endif

package msg_arbiter_pkg;

    localparam int unsigned N_SRC_DEFAULT     = `N_SRC;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hFF;

    // Frame sequencing shared with cmd_decoder so both ends agree on framing
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_ADDR    = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CHK     = 3'd5
    } frame_state_e;

    // Index width for n sources, never below one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_arbiter_rr_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr, wrapping.
module rr_arbiter
    import msg_arbiter_pkg::*;
#(
    parameter  int unsigned N  = N_SRC_DEFAULT,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] ix;

    // Scan ptr+1 .. ptr (mod N) and keep the first hit
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        ix           = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            ix = IW'((32'(ptr) + k) % N);
            if (!any && req[ix]) begin
                any              = 1'b1;
                grant_idx        = ix;
                grant_onehot[ix] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_arbiter_rr.sv
// Round-robin message arbiter framing SYNC, ADDR, LEN, payload[, CHK] onto a byte stream.
// Define MSG_ARBITER_CHK_EN to append the XOR checksum byte.
module msg_arbiter_rr
    import msg_arbiter_pkg::*;
#(
    parameter  int unsigned N_SRC       = N_SRC_DEFAULT,
    parameter  logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter  int unsigned ADDR_OFFSET = 0,
    localparam int unsigned IDX_W       = idx_width(N_SRC)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [N_SRC-1:0]     have_msg_bus,
    input  logic [8*N_SRC-1:0]   len_bus,
    input  logic [8*N_SRC-1:0]   data_bus,
    output logic [N_SRC-1:0]     rdreq_bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 underrun
);

`ifdef MSG_ARBITER_CHK_EN
    localparam frame_state_e ST_AFTER_PAYLOAD = ST_CHK;
`else
    localparam frame_state_e ST_AFTER_PAYLOAD = ST_IDLE;
`endif

    frame_state_e       state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   grant_idx_n;
    logic [N_SRC-1:0]   gnt_oh, gnt_oh_n;
    logic [7:0]         cnt, cnt_n;
    logic [7:0]         tx_data_n;
    logic               tx_valid_n;
    logic               busy_n;
    logic               underrun_n;
`ifdef MSG_ARBITER_CHK_EN
    logic [7:0]         chk, chk_n;
`endif

    logic [N_SRC-1:0]   arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [7:0]         arb_len;
    logic [7:0]         gnt_data;
    logic [7:0]         addr_byte;
    logic               gnt_has_msg;
    logic               slot;
    logic               load;
    logic [7:0]         load_byte;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req          (have_msg_bus),
        .ptr          (rr_ptr),
        .grant_onehot (arb_oh),
        .grant_idx    (arb_idx),
        .any          (arb_any)
    );

    assign arb_len     = len_bus[{arb_idx, 3'b000} +: 8];
    assign gnt_data    = data_bus[{grant_idx, 3'b000} +: 8];
    assign gnt_has_msg = |(have_msg_bus & gnt_oh);
    assign addr_byte   = 8'(32'(grant_idx) + ADDR_OFFSET);
    assign slot        = !tx_valid || tx_ready;

    // Next-state, byte selection and pop strobe; the pop must coincide with the byte load
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        grant_idx_n = grant_idx;
        gnt_oh_n    = gnt_oh;
        cnt_n       = cnt;
        load        = 1'b0;
        load_byte   = 8'h00;
        underrun_n  = 1'b0;
        rdreq_bus   = '0;
`ifdef MSG_ARBITER_CHK_EN
        chk_n       = chk;
`endif
        case (state)
            ST_IDLE: begin
                if (arb_any && slot) begin
                    grant_idx_n = arb_idx;
                    gnt_oh_n    = arb_oh;
                    rr_ptr_n    = arb_idx;
                    cnt_n       = arb_len;
                    state_n     = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (slot) begin
                    load      = 1'b1;
                    load_byte = SYNC_BYTE;
                    state_n   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (slot) begin
                    load      = 1'b1;
                    load_byte = addr_byte;
`ifdef MSG_ARBITER_CHK_EN
                    chk_n     = addr_byte;
`endif
                    state_n   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (slot) begin
                    load      = 1'b1;
                    load_byte = cnt;
`ifdef MSG_ARBITER_CHK_EN
                    chk_n     = chk ^ cnt;
`endif
                    state_n   = (cnt == 8'd0) ? ST_AFTER_PAYLOAD : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (slot) begin
                    load = 1'b1;
                    if (gnt_has_msg) begin
                        load_byte = gnt_data;
                        rdreq_bus = gnt_oh;
                    end else begin
                        load_byte  = 8'h00;
                        underrun_n = 1'b1;
                    end
`ifdef MSG_ARBITER_CHK_EN
                    chk_n = chk ^ load_byte;
`endif
                    cnt_n = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_n = ST_AFTER_PAYLOAD;
                    end
                end
            end
`ifdef MSG_ARBITER_CHK_EN
            ST_CHK: begin
                if (slot) begin
                    load      = 1'b1;
                    load_byte = chk;
                    state_n   = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        tx_valid_n = load | (tx_valid & ~tx_ready);
        tx_data_n  = load ? load_byte : tx_data;
        busy_n     = (state_n != ST_IDLE);
    end

    // State, grant, counter and output byte register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(N_SRC - 1);
            grant_idx <= '0;
            gnt_oh    <= '0;
            cnt       <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
`ifdef MSG_ARBITER_CHK_EN
            chk       <= 8'h00;
`endif
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            grant_idx <= grant_idx_n;
            gnt_oh    <= gnt_oh_n;
            cnt       <= cnt_n;
            tx_data   <= tx_data_n;
            tx_valid  <= tx_valid_n;
            busy      <= busy_n;
            underrun  <= underrun_n;
`ifdef MSG_ARBITER_CHK_EN
            chk       <= chk_n;
`endif
        end
    end

endmodule

// File: tb/tb_msg_arbiter_rr.sv
// Directed bench for msg_arbiter_rr (honours MSG_ARBITER_CHK_EN in its expected frames).
module tb_msg_arbiter_rr;

    localparam int unsigned N  = 24;
    localparam int unsigned IW = 5;

    typedef logic [7:0] byte_q_t [$];

    logic             clk = 1'b0;
    logic             n_rst;
    logic [N-1:0]     have_msg_bus;
    logic [8*N-1:0]   len_bus;
    logic [8*N-1:0]   data_bus;
    logic [N-1:0]     rdreq_bus;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [IW-1:0]    grant_idx;
    logic             underrun;

    // Source model state driven by the stimulus process
    logic [N-1:0]     armed;
    int unsigned      avail    [N];
    int unsigned      base_pop [N];
    logic [7:0]       len_v    [N];
    logic [7:0]       pay      [N][16];

    // Observed by the monitor process
    int unsigned      pop_total [N] = '{default: 0};
    int unsigned      n_under   = 0;
    int unsigned      n_multi   = 0;
    int unsigned      n_unstable = 0;
    logic             prev_stall = 1'b0;
    logic [7:0]       prev_data  = 8'h00;
    byte_q_t          cap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    msg_arbiter_rr dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .have_msg_bus (have_msg_bus),
        .len_bus      (len_bus),
        .data_bus     (data_bus),
        .rdreq_bus    (rdreq_bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .underrun     (underrun)
    );

    // Show-ahead sources: have_msg holds until 'avail' bytes have been popped
    always_comb begin
        for (int i = 0; i < N; i++) begin
            have_msg_bus[i]    = armed[i] && ((pop_total[i] - base_pop[i]) < avail[i]);
            len_bus[8*i +: 8]  = len_v[i];
            data_bus[8*i +: 8] = pay[i][(pop_total[i] - base_pop[i]) % 16];
        end
    end

    // Stream capture, pop counting and stall-stability tracking
    always @(posedge clk) begin
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        if (underrun) n_under <= n_under + 1;
        if ($countones(rdreq_bus) > 1) n_multi <= n_multi + 1;
        for (int i = 0; i < N; i++) begin
            if (rdreq_bus[i]) pop_total[i] <= pop_total[i] + 1;
        end
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) n_unstable <= n_unstable + 1;
        prev_stall <= n_rst && tx_valid && !tx_ready;
        prev_data  <= tx_data;
    end

    task automatic arm(input int s, input int ln, input int av,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
        len_v[s]    = 8'(ln);
        pay[s][0]   = b0;
        pay[s][1]   = b1;
        pay[s][2]   = b2;
        pay[s][3]   = b3;
        base_pop[s] = pop_total[s];
        avail[s]    = av;
        armed[s]    = 1'b1;
    endtask

    // Expected frame for source s; bytes beyond 'av' are underrun zeros
    task automatic build_exp(input int s, input int ln, input int av, output byte_q_t e);
        logic [7:0] c;
        logic [7:0] b;
        e = {};
        e.push_back(8'hFF);
        e.push_back(8'(s));
        e.push_back(8'(ln));
        c = 8'(s) ^ 8'(ln);
        for (int k = 0; k < ln; k++) begin
            b = (k < av) ? pay[s][k] : 8'h00;
            e.push_back(b);
            c = c ^ b;
        end
`ifdef MSG_ARBITER_CHK_EN
        e.push_back(c);
`endif
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // Bounded wait for an idle DUT with no pending request; optional 1-0-0-1 tx_ready pattern
    task automatic wait_quiet(input int max_cyc, input bit stall, input string tag);
        int c;
        bit done;
        c = 0;
        done = 1'b0;
        while (!done && c < max_cyc) begin
            if (stall) tx_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            c++;
            if (!busy && !tx_valid && have_msg_bus == '0) done = 1'b1;
        end
        tx_ready = 1'b1;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_timeout: not idle after %0d cycles", tag, max_cyc);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        arm(4, 1, 1, 8'h44, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tx: valid=%b data=%h busy=%b, want 0 00 0", tx_valid, tx_data, busy);
        end
        n_cmp++;
        if (grant_idx !== '0 || underrun !== 1'b0 || rdreq_bus !== '0) begin
            n_bad++;
            $display("FAIL reset_misc: grant=%0d underrun=%b rdreq=%h, want 0 0 0", grant_idx, underrun, rdreq_bus);
        end
        armed[4] = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        byte_q_t e;
        int unsigned p0;
        arm(5, 3, 3, 8'hA1, 8'hA2, 8'hA3, 8'h00);
        build_exp(5, 3, 3, e);
        p0 = pop_total[5];
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_grant_cycle: valid=%b busy=%b, want 0 1", tx_valid, busy);
        end
        for (int j = 0; j < e.size(); j++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== e[j] || busy !== (j != e.size() - 1)) begin
                n_bad++;
                $display("FAIL t1_byte%0d: valid=%b data=%h busy=%b, want 1 %h %b",
                         j, tx_valid, tx_data, busy, e[j], (j != e.size() - 1));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_end: valid=%b busy=%b, want 0 0", tx_valid, busy);
        end
        n_cmp++;
        if (pop_total[5] - p0 != 3) begin
            n_bad++;
            $display("FAIL t1_rdreq: got %0d pops, want 3", pop_total[5] - p0);
        end
        armed[5] = 1'b0;
    endtask

    task automatic test_rr_order();
        byte_q_t e2a, e9, e2b, ea;
        int base;
        int c;
        logic got;
        do_reset();
        base = cap.size();
        arm(2, 1, 1, 8'h2A, 8'h00, 8'h00, 8'h00);
        arm(9, 1, 1, 8'h9B, 8'h00, 8'h00, 8'h00);
        build_exp(2, 1, 1, e2a);
        build_exp(9, 1, 1, e9);
        c = 0;
        got = 1'b0;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            if (busy && grant_idx == IW'(9)) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL t2_grant9: src9 not granted within 40 cycles, grant=%0d", grant_idx);
        end
        arm(2, 1, 1, 8'h2C, 8'h00, 8'h00, 8'h00);
        build_exp(2, 1, 1, e2b);
        wait_quiet(100, 1'b0, "t2");
        ea = {e2a, e9, e2b};
        n_cmp++;
        if (cap.size() - base != ea.size()) begin
            n_bad++;
            $display("FAIL t2_len: got %0d bytes, want %0d", cap.size() - base, ea.size());
        end
        for (int k = 0; k < ea.size(); k++) begin
            n_cmp++;
            if (base + k >= cap.size() || cap[base + k] !== ea[k]) begin
                n_bad++;
                $display("FAIL t2_byte%0d: got %h, want %h", k,
                         (base + k < cap.size()) ? cap[base + k] : 8'hxx, ea[k]);
            end
        end
        armed[2] = 1'b0;
        armed[9] = 1'b0;
    endtask

    task automatic test_zero_len();
        byte_q_t e;
        int base;
        int unsigned p0;
        int c;
        base = cap.size();
        p0 = pop_total[0];
        arm(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        build_exp(0, 0, 1, e);
        c = 0;
        while (!busy && c < 10) begin
            @(negedge clk);
            c++;
        end
        armed[0] = 1'b0;
        wait_quiet(50, 1'b0, "t3");
        n_cmp++;
        if (cap.size() - base != e.size()) begin
            n_bad++;
            $display("FAIL t3_len: got %0d bytes, want %0d", cap.size() - base, e.size());
        end
        for (int k = 0; k < e.size(); k++) begin
            n_cmp++;
            if (base + k >= cap.size() || cap[base + k] !== e[k]) begin
                n_bad++;
                $display("FAIL t3_byte%0d: got %h, want %h", k,
                         (base + k < cap.size()) ? cap[base + k] : 8'hxx, e[k]);
            end
        end
        n_cmp++;
        if (pop_total[0] != p0) begin
            n_bad++;
            $display("FAIL t3_rdreq: got %0d pops, want 0", pop_total[0] - p0);
        end
    endtask

    task automatic test_backpressure();
        byte_q_t e;
        int base;
        int unsigned p0;
        base = cap.size();
        p0 = pop_total[12];
        arm(12, 4, 4, 8'h11, 8'h22, 8'h33, 8'h44);
        build_exp(12, 4, 4, e);
        wait_quiet(200, 1'b1, "t4");
        n_cmp++;
        if (cap.size() - base != e.size()) begin
            n_bad++;
            $display("FAIL t4_len: got %0d bytes, want %0d", cap.size() - base, e.size());
        end
        for (int k = 0; k < e.size(); k++) begin
            n_cmp++;
            if (base + k >= cap.size() || cap[base + k] !== e[k]) begin
                n_bad++;
                $display("FAIL t4_byte%0d: got %h, want %h", k,
                         (base + k < cap.size()) ? cap[base + k] : 8'hxx, e[k]);
            end
        end
        n_cmp++;
        if (pop_total[12] - p0 != 4) begin
            n_bad++;
            $display("FAIL t4_rdreq: got %0d pops, want 4", pop_total[12] - p0);
        end
        n_cmp++;
        if (n_unstable != 0) begin
            n_bad++;
            $display("FAIL t4_stable: %0d stalled bytes changed, want 0", n_unstable);
        end
        armed[12] = 1'b0;
    endtask

    task automatic test_underrun();
        byte_q_t e;
        int base;
        int unsigned p0;
        int unsigned u0;
        base = cap.size();
        p0 = pop_total[3];
        u0 = n_under;
        arm(3, 4, 2, 8'h31, 8'h32, 8'h33, 8'h34);
        build_exp(3, 4, 2, e);
        wait_quiet(100, 1'b0, "t5");
        n_cmp++;
        if (cap.size() - base != e.size()) begin
            n_bad++;
            $display("FAIL t5_len: got %0d bytes, want %0d", cap.size() - base, e.size());
        end
        for (int k = 0; k < e.size(); k++) begin
            n_cmp++;
            if (base + k >= cap.size() || cap[base + k] !== e[k]) begin
                n_bad++;
                $display("FAIL t5_byte%0d: got %h, want %h", k,
                         (base + k < cap.size()) ? cap[base + k] : 8'hxx, e[k]);
            end
        end
        n_cmp++;
        if (n_under - u0 != 2) begin
            n_bad++;
            $display("FAIL t5_underrun: got %0d pulses, want 2", n_under - u0);
        end
        n_cmp++;
        if (pop_total[3] - p0 != 2) begin
            n_bad++;
            $display("FAIL t5_rdreq: got %0d pops, want 2", pop_total[3] - p0);
        end
        armed[3] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t e;
        int base;
        int unsigned p0;
        int c;
        p0 = pop_total[7];
        arm(7, 4, 4, 8'h71, 8'h72, 8'h73, 8'h74);
        c = 0;
        while (pop_total[7] == p0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (pop_total[7] == p0) begin
            n_bad++;
            $display("FAIL t6_payload: no pop within 20 cycles");
        end
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
            grant_idx !== '0 || underrun !== 1'b0 || rdreq_bus !== '0) begin
            n_bad++;
            $display("FAIL t6_async: valid=%b data=%h busy=%b grant=%0d underrun=%b rdreq=%h, want all 0",
                     tx_valid, tx_data, busy, grant_idx, underrun, rdreq_bus);
        end
        armed[7] = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        base = cap.size();
        arm(7, 1, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
        build_exp(7, 1, 1, e);
        wait_quiet(50, 1'b0, "t6");
        n_cmp++;
        if (cap.size() - base != e.size()) begin
            n_bad++;
            $display("FAIL t6_len: got %0d bytes, want %0d", cap.size() - base, e.size());
        end
        for (int k = 0; k < e.size(); k++) begin
            n_cmp++;
            if (base + k >= cap.size() || cap[base + k] !== e[k]) begin
                n_bad++;
                $display("FAIL t6_byte%0d: got %h, want %h", k,
                         (base + k < cap.size()) ? cap[base + k] : 8'hxx, e[k]);
            end
        end
        armed[7] = 1'b0;
    endtask

    task automatic test_single_rdreq();
        n_cmp++;
        if (n_multi != 0) begin
            n_bad++;
            $display("FAIL multi_rdreq: %0d cycles with >1 rdreq bit, want 0", n_multi);
        end
    endtask

    initial begin
        tx_ready = 1'b1;
        n_rst    = 1'b0;
        armed    = '0;
        for (int i = 0; i < N; i++) begin
            avail[i]    = 0;
            base_pop[i] = 0;
            len_v[i]    = 8'h00;
            for (int k = 0; k < 16; k++) pay[i][k] = 8'h00;
        end
        test_reset();
        test_basic_frame();
        test_rr_order();
        test_zero_len();
        test_backpressure();
        test_underrun();
        test_reset_mid_frame();
        test_single_rdreq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
